// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver: sequences timed set/reset pulses into a downstream SR flop and reports completion.
// Readback checking of q_fb is built only when SR_CMD_READBACK_EN is defined.
module sr_cmd_driver #(
    parameter int PULSE_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_val,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt
);
    localparam logic [3:0] PW_LAST = (PULSE_W <= 1) ? 4'd0 : 4'(PULSE_W - 1);

    typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       val_q, val_d;
    logic       live_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            val_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready) begin
                state_d = PULSE;
                cnt_d   = 4'd0;
                val_d   = cmd_val;
            end
            PULSE: if (cnt_q == PW_LAST) state_d = SETTLE;
                   else cnt_d = cnt_q + 4'd1;
            SETTLE: state_d = CHECK;
            default: state_d = IDLE;
        endcase
    end

    // live_q keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = live_q && (state_q == IDLE);
    assign s         = (state_q == PULSE) && val_q;
    assign r         = (state_q == PULSE) && !val_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == CHECK;

`ifdef SR_CMD_READBACK_EN
    logic       err_q;
    logic [7:0] err_cnt_q;
    logic       mis;

    // q_fb is sampled on the edge leaving SETTLE so err is a clean flop output during CHECK
    assign mis = (state_q == SETTLE) && (q_fb != val_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_q <= mis;
            if (mis && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign err         = 1'b0;
    assign err_cnt     = 8'd0;
`endif
endmodule

// File: tb/tb_sr_cmd_driver.sv
// tb_sr_cmd_driver: directed vector table plus corner sequences for sr_cmd_driver.
module tb_sr_cmd_driver;
`ifdef SR_CMD_READBACK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v2 = 1'b0, val2 = 1'b0, q2 = 1'b0;
    logic       rdy2, s2, r2, busy2, done2, err2;
    logic [7:0] cnt2;
    logic       rdy1, s1, r1, busy1, done1, err1;
    logic [7:0] cnt1;
    logic       rdy15, s15, r15, busy15, done15, err15;
    logic [7:0] cnt15;
    logic       rdy0, s0, r0, busy0, done0, err0;
    logic [7:0] cnt0;

    sr_cmd_driver #(.PULSE_W(2)) u2 (.clk(clk), .rst_n(rst_n), .cmd_valid(v2), .cmd_val(val2),
        .cmd_ready(rdy2), .s(s2), .r(r2), .q_fb(q2), .busy(busy2), .done(done2), .err(err2), .err_cnt(cnt2));
    sr_cmd_driver #(.PULSE_W(1)) u1 (.clk(clk), .rst_n(rst_n), .cmd_valid(1'b1), .cmd_val(1'b0),
        .cmd_ready(rdy1), .s(s1), .r(r1), .q_fb(1'b0), .busy(busy1), .done(done1), .err(err1), .err_cnt(cnt1));
    sr_cmd_driver #(.PULSE_W(15)) u15 (.clk(clk), .rst_n(rst_n), .cmd_valid(1'b1), .cmd_val(1'b1),
        .cmd_ready(rdy15), .s(s15), .r(r15), .q_fb(1'b1), .busy(busy15), .done(done15), .err(err15), .err_cnt(cnt15));
    sr_cmd_driver #(.PULSE_W(0)) u0 (.clk(clk), .rst_n(rst_n), .cmd_valid(1'b1), .cmd_val(1'b1),
        .cmd_ready(rdy0), .s(s0), .r(r0), .q_fb(1'b1), .busy(busy0), .done(done0), .err(err0), .err_cnt(cnt0));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("sr11_u2", int'({s2, r2} == 2'b11), 0);
        chk("sr11_u1", int'({s1, r1} == 2'b11), 0);
        chk("sr11_u15", int'({s15, r15} == 2'b11), 0);
        chk("sr11_u0", int'({s0, r0} == 2'b11), 0);
    end

    // {cmd_valid, cmd_val, q_fb, exp cmd_ready, s, r, busy, done, err}
    typedef struct packed {
        logic v, val, q, rdy, s, r, busy, done, err;
    } vec_t;
    vec_t tbl [15];

    function automatic logic done_of(input int k);
        return (k == 1) ? done1 : (k == 15) ? done15 : done0;
    endfunction

    task automatic measure(input int k, output int per);
        bit seen = 1'b0;
        per = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            seen = done_of(k);
        end
        if (seen) begin
            for (int n = 1; n <= 60; n++) begin
                @(posedge clk); #1;
                if (done_of(k)) begin
                    per = n;
                    break;
                end
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            ok = done2;
        end
    endtask

    initial begin
        int per;
        bit ok;
        tbl[0]  = 9'b1_1_1_0_1_0_1_0_0;
        tbl[1]  = 9'b0_0_1_0_1_0_1_0_0;
        tbl[2]  = 9'b0_0_1_0_0_0_1_0_0;
        tbl[3]  = 9'b0_0_1_0_0_0_1_1_0;
        tbl[4]  = 9'b0_0_1_1_0_0_0_0_0;
        tbl[5]  = 9'b1_0_1_0_0_1_1_0_0;
        tbl[6]  = 9'b1_1_1_0_0_1_1_0_0;
        tbl[7]  = 9'b0_0_1_0_0_0_1_0_0;
        tbl[8]  = 9'b0_0_1_0_0_0_1_1_1;
        tbl[9]  = 9'b0_0_1_1_0_0_0_0_0;
        tbl[10] = 9'b1_0_0_0_0_1_1_0_0;
        tbl[11] = 9'b0_0_0_0_0_1_1_0_0;
        tbl[12] = 9'b0_0_0_0_0_0_1_0_0;
        tbl[13] = 9'b0_0_0_0_0_0_1_1_0;
        tbl[14] = 9'b0_0_0_1_0_0_0_0_0;

        #2;
        chk("rst_ready", int'(rdy2), 0);
        chk("rst_sr", int'({s2, r2}), 0);
        chk("rst_busy", int'(busy2), 0);
        chk("rst_done", int'(done2), 0);
        chk("rst_err", int'(err2), 0);
        chk("rst_errcnt", int'(cnt2), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rel_ready_pre", int'(rdy2), 0);
        @(posedge clk); #1;
        chk("rel_ready", int'(rdy2), 1);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            v2 = tbl[i].v; val2 = tbl[i].val; q2 = tbl[i].q;
            @(posedge clk); #1;
            chk($sformatf("row%0d.ready", i), int'(rdy2), int'(tbl[i].rdy));
            chk($sformatf("row%0d.s", i), int'(s2), int'(tbl[i].s));
            chk($sformatf("row%0d.r", i), int'(r2), int'(tbl[i].r));
            chk($sformatf("row%0d.busy", i), int'(busy2), int'(tbl[i].busy));
            chk($sformatf("row%0d.done", i), int'(done2), int'(tbl[i].done));
            chk($sformatf("row%0d.err", i), int'(err2), int'(tbl[i].err & EN));
        end
        chk("errcnt_after_tbl", int'(cnt2), EN ? 1 : 0);

        @(negedge clk);
        v2 = 1'b1; val2 = 1'b0; q2 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wait_done(ok);
            chk("sat_done", int'(ok), 1);
            if (!ok) break;
            chk("sat_err", int'(err2), int'(EN));
            if (i == 252) chk("errcnt_254", int'(cnt2), EN ? 254 : 0);
        end
        chk("errcnt_255", int'(cnt2), EN ? 255 : 0);
        @(negedge clk) v2 = 1'b0;
        @(posedge clk); #1;
        chk("sat_idle", int'(rdy2), 1);
        chk("errcnt_hold", int'(cnt2), EN ? 255 : 0);

        @(negedge clk);
        v2 = 1'b1; val2 = 1'b1; q2 = 1'b0;
        @(posedge clk); #1;
        chk("mid_s", int'(s2), 1);
        @(negedge clk);
        v2 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_sr", int'({s2, r2}), 0);
        chk("mid_busy", int'(busy2), 0);
        chk("mid_ready", int'(rdy2), 0);
        chk("mid_errcnt", int'(cnt2), 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_done", int'(done2), 0);
        end
        @(negedge clk) rst_n = 1'b1;
        #1 chk("mid_ready_pre", int'(rdy2), 0);
        @(posedge clk); #1;
        chk("mid_ready_post", int'(rdy2), 1);
        chk("mid_done_post", int'(done2), 0);
        chk("mid_err_post", int'(err2), 0);

        measure(1, per);
        chk("period_pw1", per, 4);
        measure(1, per);
        chk("period_pw1_b", per, 4);
        measure(15, per);
        chk("period_pw15", per, 18);
        measure(0, per);
        chk("period_pw0", per, 4);
        chk("u15_err", int'(err15), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sr_cmd_driver.md
SR_CMD_DRIVER -- requirements
Module: sr_cmd_driver

Interface
REQ-001 Parameter: PULSE_W, 2, number of clock cycles a set or reset command is held on s/r (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: cmd_valid  input  1  command request from upstream.
REQ-005 Port: cmd_val  input  1  target level to load into the downstream SR flop (1 = set, 0 = reset).
REQ-006 Port: cmd_ready  output  1  high when a command can be accepted.
REQ-007 Port: s  output  1  set command to the downstream SR flop.
REQ-008 Port: r  output  1  reset command to the downstream SR flop.
REQ-009 Port: q_fb  input  1  q readback from the downstream SR flop.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle pulse at command completion.
REQ-012 Port: err  output  1  one-cycle pulse, coincident with done, on readback mismatch.
REQ-013 Port: err_cnt  output  8  saturating count of readback mismatches.

Function
REQ-014 The block SHALL be a four-state FSM, IDLE -> PULSE -> SETTLE -> CHECK -> IDLE, with all outputs registered or decoded from registered state only.
REQ-015 In IDLE, cmd_ready SHALL be 1; in all other states it SHALL be 0, and cmd_valid SHALL be ignored.
REQ-016 A handshake occurs on the rising edge where cmd_valid=1 and cmd_ready=1; cmd_val SHALL be latched on that edge and the FSM SHALL enter PULSE.
REQ-017 In PULSE, s SHALL equal the latched value and r SHALL equal its inverse, for exactly PULSE_W cycles, counted by a 4-bit counter.
REQ-018 Outside PULSE, s and r SHALL both be 0. The encoding {s,r}=2'b11 SHALL never be driven in any state, including during reset.
REQ-019 SETTLE SHALL last exactly one cycle with s=r=0, so that q_fb can propagate.
REQ-020 CHECK SHALL last exactly one cycle. done SHALL be 1 for that cycle and the FSM SHALL return to IDLE on the next edge.
REQ-021 Latency: if the handshake is at edge E0, s/r are asserted for cycles E0+1..E0+PULSE_W, done is high in cycle E0+PULSE_W+2, and cmd_ready is high in cycle E0+PULSE_W+3.
REQ-022 A command whose target equals the current q_fb SHALL still be issued in full; there is no skip optimisation.
REQ-023 Back-to-back commands: with cmd_valid held high, a new handshake SHALL occur on the first edge in IDLE, giving a throughput of one command per PULSE_W+3 cycles.
REQ-024 err_cnt SHALL increment by 1 on every err pulse, SHALL saturate at 255, and SHALL NOT wrap.
REQ-025 A PULSE_W value of 0 SHALL behave as 1.

Reset
REQ-026 When rst_n=0, the following SHALL apply immediately and independently of clk: state=IDLE, s=0, r=0, done=0, err=0, err_cnt=0, busy=0, cmd_ready=0.
REQ-027 Reset asserted mid-command SHALL abandon that command; no done or err SHALL be produced for it.
REQ-028 cmd_ready SHALL rise in the first cycle after the first rising edge following reset deassertion.

Configuration
REQ-029 Macro SR_CMD_READBACK_EN SHALL control readback checking.
REQ-030 With SR_CMD_READBACK_EN defined, in CHECK err SHALL be 1 when q_fb differs from the latched cmd_val, and err_cnt SHALL update per REQ-024.
REQ-031 Without SR_CMD_READBACK_EN, q_fb SHALL be unused, err SHALL be constant 0 and err_cnt constant 0. FSM states and timing SHALL be identical to the enabled build.

Verification
REQ-032 Set command (PULSE_W=2): cmd_val=1 accepted at E0 -> s=1,r=0 in cycles E0+1..E0+2; s=r=0 after; done in cycle E0+4; cmd_ready in cycle E0+5.
REQ-033 Readback mismatch (macro on): issue cmd_val=0 with q_fb tied 1 -> err=1 with done; err_cnt goes 0 -> 1; repeat 300 commands -> err_cnt=255 and holds.
REQ-034 Busy rejection: pulse cmd_valid with cmd_val=1 while in PULSE -> no second s pulse; that request never accepted; cmd_ready=0 until CHECK completes.
REQ-035 Reset mid-PULSE: drop rst_n during a set command -> s=r=0 without waiting for a clock edge; no done; err_cnt=0; after release, cmd_ready=1 one edge later.
REQ-036 Whole-run checks: assert {s,r}!=2'b11 on every cycle of every test; with cmd_valid held high, done pulses every PULSE_W+3 cycles for PULSE_W=1 and for PULSE_W=15.
